// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums plus default widths.
package alu_pkg;

  localparam int ALU_N = 32;
  localparam int ALU_M = 4;

  typedef enum logic [ALU_M-1:0] {
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_ADD2 = 4'b0011,
    OP_SUB2 = 4'b0100,
    OP_MUL  = 4'b0101,
    OP_DIV  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_AND  = 4'b1000,
    OP_XOR  = 4'b1001,
    OP_SLL  = 4'b1010,
    OP_SRL  = 4'b1011,
    OP_SLT  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a requester and the sequential ALU.
interface seq_alu_if import alu_pkg::*; #(
  parameter int N = ALU_N,
  parameter int M = ALU_M
);

  logic         start;
  logic [M-1:0] alu_decode;
  logic [N-1:0] rda;
  logic [N-1:0] rdx;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] remain;
  logic         zero;

  modport master (
    output start, alu_decode, rda, rdx,
    input  busy, done, result, hi, lo, remain, zero
  );

  modport slave (
    input  start, alu_decode, rda, rdx,
    output busy, done, result, hi, lo, remain, zero
  );

endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider; o_result is the value after the current step.
module muldiv_iter import alu_pkg::*; #(
  parameter int N = ALU_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_op,
  input  logic [N-1:0]   i_opa,
  input  logic [N-1:0]   i_opb,
  output logic [2*N-1:0] o_result,
  output logic           o_finish
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_b;
  logic [CW-1:0]  r_cnt;
  logic           r_run;
  logic           r_div;

  logic [N:0]     w_sum;
  logic [N:0]     w_trial;
  logic [N:0]     w_diff;
  logic [2*N-1:0] w_next;

  // Multiply: upper half accumulates, pair shifts right. Divide: {remainder, quotient} shifts left;
  // the borrow out of the (N+1)-bit trial subtraction decides the quotient bit.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_trial = {r_acc[2*N-1:N], r_acc[N-1]};
    w_diff  = w_trial - {1'b0, r_b};
    w_next  = {w_sum, r_acc[N-1:1]};
    if (r_div) begin
      if (!w_diff[N]) begin
        w_next = {w_diff[N-1:0], r_acc[N-2:0], 1'b1};
      end else begin
        w_next = {w_trial[N-1:0], r_acc[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_op ? {{N{1'b0}}, i_opa} : {{N{1'b0}}, i_opb};
      r_b   <= i_op ? i_opb : i_opa;
      r_cnt <= '0;
      r_run <= 1'b1;
      r_div <= i_op;
    end else if (r_run) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_run <= 1'b0;
    end
  end

  assign o_result = w_next;
  assign o_finish = r_run && (r_cnt == LAST);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: FSM, single-cycle datapath and output registers; MUL/DIV iterate in muldiv_iter.
module seq_alu import alu_pkg::*; #(
  parameter int N = ALU_N,
  parameter int M = ALU_M
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);

  localparam int SW = $clog2(N);

  state_e         r_state;
  state_e         w_next;
  alu_op_e        w_op;
  logic           w_accept;
  logic           w_div0;
  logic           w_long;
  logic           w_finish;
  logic           w_iter_done;
  logic [N-1:0]   w_alu;
  logic [2*N-1:0] w_iter;

  logic [N-1:0]   r_result;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;
  logic [N-1:0]   r_remain;
  logic           r_zero;

  assign w_op        = alu_op_e'(ALU_M'(bus.alu_decode[M-1:0]));
  assign w_div0      = (w_op == OP_DIV) && (bus.rdx == '0);
  assign w_long      = (w_op == OP_MUL) || ((w_op == OP_DIV) && !w_div0);
  assign w_accept    = (r_state == ST_IDLE) && bus.start;
  assign w_iter_done = w_finish && ((r_state == ST_MUL) || (r_state == ST_DIV));

  // DIV here only covers the divide-by-zero shortcut; MUL never takes this path.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD, OP_ADD2: w_alu = bus.rda + bus.rdx;
      OP_SUB, OP_SUB2: w_alu = bus.rda - bus.rdx;
      OP_OR:           w_alu = bus.rda | bus.rdx;
      OP_AND:          w_alu = bus.rda & bus.rdx;
      OP_XOR:          w_alu = bus.rda ^ bus.rdx;
      OP_SLL:          w_alu = bus.rda << bus.rdx[SW-1:0];
      OP_SRL:          w_alu = bus.rda >> bus.rdx[SW-1:0];
      OP_SLT:          w_alu = {{(N-1){1'b0}}, (bus.rda < bus.rdx)};
      OP_DIV:          w_alu = '1;
      default:         w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_op == OP_MUL)  w_next = ST_MUL;
          else if (w_long)     w_next = ST_DIV;
          else                 w_next = ST_FIN;
        end
      end
      ST_MUL, ST_DIV: if (w_iter_done) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_remain <= '0;
      r_zero   <= 1'b1;
    end else begin
      if (w_accept && !w_long) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        if (w_div0) r_remain <= bus.rda;
      end
      if (w_iter_done) begin
        r_result <= w_iter[N-1:0];
        r_zero   <= (w_iter[N-1:0] == '0);
        if (r_state == ST_MUL) begin
          r_hi <= w_iter[2*N-1:N];
          r_lo <= w_iter[N-1:0];
        end else begin
          r_remain <= w_iter[2*N-1:N];
        end
      end
    end
  end

  muldiv_iter #(.N(N)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept && w_long),
    .i_op     (w_op == OP_DIV),
    .i_opa    (bus.rda),
    .i_opb    (bus.rdx),
    .o_result (w_iter),
    .o_finish (w_finish)
  );

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_FIN);
  assign bus.result = r_result;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.remain = r_remain;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [31:0] expResult = '0;
  logic [31:0] expHi     = '0;
  logic [31:0] expLo     = '0;
  logic [31:0] expRem    = '0;
  logic        expZero   = 1'b1;

  seq_alu_if #(.N(N), .M(4)) bus ();

  seq_alu #(.N(N), .M(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected architectural effect of one completed operation.
  task automatic referenceModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      4'b0001, 4'b0011: expResult = a + b;
      4'b0010, 4'b0100: expResult = a - b;
      4'b0101: begin
        prod      = {32'd0, a} * {32'd0, b};
        expHi     = prod[63:32];
        expLo     = prod[31:0];
        expResult = prod[31:0];
      end
      4'b0110: begin
        if (b == 0) begin
          expResult = 32'hFFFF_FFFF;
          expRem    = a;
        end else begin
          expResult = a / b;
          expRem    = a % b;
        end
      end
      4'b0111: expResult = a | b;
      4'b1000: expResult = a & b;
      4'b1001: expResult = a ^ b;
      4'b1010: expResult = a << (b % 32);
      4'b1011: expResult = a >> (b % 32);
      4'b1100: expResult = (a < b) ? 32'd1 : 32'd0;
      default: expResult = 32'd0;
    endcase
    expZero = (expResult == 0);
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".result"}, 64'(bus.result), 64'(expResult));
    checkOutput({where, ".zero"},   64'(bus.zero),   64'(expZero));
    checkOutput({where, ".hi"},     64'(bus.hi),     64'(expHi));
    checkOutput({where, ".lo"},     64'(bus.lo),     64'(expLo));
    checkOutput({where, ".remain"}, 64'(bus.remain), 64'(expRem));
  endtask

  // Issue one op from IDLE, scramble inputs after acceptance, optionally poke start mid-op.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit intrude);
    int cyc;
    int lat;
    bit seen;
    bus.start      = 1'b1;
    bus.alu_decode = op;
    bus.rda        = a;
    bus.rdx        = b;
    lat  = (op == 4'b0101 || (op == 4'b0110 && b != 0)) ? N + 1 : 1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start      = 1'b0;
        bus.alu_decode = 4'($urandom);
        bus.rda        = $urandom;
        bus.rdx        = $urandom;
      end
      if (intrude && cyc == 5) begin
        bus.start      = 1'b1;
        bus.alu_decode = 4'b0001;
        bus.rda        = 32'd1;
        bus.rdx        = 32'd1;
      end else if (intrude && cyc == 6) begin
        bus.start = 1'b0;
      end
      seen = bus.done;
      checkOutput("busy", 64'(bus.busy), 64'(1));
    end
    checkOutput("latency", 64'(cyc), 64'(lat));
    referenceModel(op, a, b);
    checkAll("op");
    @(negedge clk);
    checkOutput("donePulse", 64'(bus.done), 64'(0));
    checkOutput("idleBusy",  64'(bus.busy), 64'(0));
  endtask

  task automatic resetMidMul();
    bus.start      = 1'b1;
    bus.alu_decode = 4'b0101;
    bus.rda        = $urandom;
    bus.rdx        = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.alu_decode = 4'b0001;
    bus.rda        = 32'd4;
    bus.rdx        = 32'd4;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    expResult = '0; expHi = '0; expLo = '0; expRem = '0; expZero = 1'b1;
    checkOutput("rstBusy", 64'(bus.busy), 64'(0));
    checkOutput("rstDone", 64'(bus.done), 64'(0));
    checkAll("rst");
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      checkOutput("postRstDone", 64'(bus.done), 64'(0));
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.start      = 1'b0;
    bus.alu_decode = '0;
    bus.rda        = '0;
    bus.rdx        = '0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 64'(bus.busy), 64'(0));
    checkOutput("resetDone", 64'(bus.done), 64'(0));
    checkAll("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(4'b0001, 32'd5, 32'd3, 1'b0);
    applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'd2, 1'b1);
    applyStimulus(4'b0110, 32'd100, 32'd7, 1'b0);
    applyStimulus(4'b0110, 32'd9, 32'd0, 1'b0);
    applyStimulus(4'b1010, 32'd1, 32'h21, 1'b0);
    applyStimulus(4'b1100, 32'd3, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(4'b1111, 32'd7, 32'd9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))  : $urandom;
      applyStimulus(op, a, b, 1'($urandom_range(0, 1)));
    end

    resetMidMul();
    applyStimulus(4'b0101, $urandom, $urandom, 1'b0);
    applyStimulus(4'b0010, 32'd3, 32'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width in bits (N >= 8, N a power of two).
REQ-002 SHALL have parameter M, default 4: opcode width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin an operation, sampled only in IDLE.
REQ-006 SHALL have port alu_decode, input, M: opcode, sampled with start.
REQ-007 SHALL have ports rda and rdx, input, N each: operands, sampled with start.
REQ-008 SHALL have port busy, output, 1: high while an operation is in progress, so a new start is not accepted.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking valid outputs.
REQ-010 SHALL have port result, output, N: registered primary result.
REQ-011 SHALL have ports hi and lo, output, N each: upper and lower halves of the last MUL product.
REQ-012 SHALL have port remain, output, N: remainder from the last DIV.
REQ-013 SHALL have port zero, output, 1: registered flag, (result == 0), updated with result.

Function
REQ-014 Opcodes SHALL be: 0001/0011 ADD, 0010/0100 SUB, 0101 MUL, 0110 DIV, 0111 OR, 1000 AND, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SLT; all others SHALL be ILLEGAL.
REQ-015 All arithmetic SHALL be unsigned and modulo 2^N, with no carry or overflow outputs.
REQ-016 SLL and SRL SHALL shift rda by rdx[$clog2(N)-1:0] only.
REQ-017 SLT SHALL give result = 1 if rda < rdx (unsigned), else 0.
REQ-018 FSM states SHALL be IDLE, MUL, DIV and FIN; start is accepted only in IDLE.
REQ-019 Single-cycle ops (ADD through SLT, excluding MUL and DIV) SHALL:
- IDLE + start -> FIN, with result and zero registered at that edge;
- FIN -> IDLE;
- assert done during FIN, one cycle after start.
REQ-020 MUL SHALL:
- go IDLE + start -> MUL;
- run N iterations of shift-add, one per cycle;
- go to FIN, with done asserted exactly N+1 cycles after start;
- then set {hi,lo} = rda*rdx (2N bits) and result = lo.
REQ-021 DIV SHALL:
- go IDLE + start -> DIV;
- run N iterations of restoring division;
- go to FIN, with done asserted N+1 cycles after start;
- then set result = rda / rdx and remain = rda % rdx.
REQ-022 DIV with rdx == 0 SHALL skip the DIV state (IDLE -> FIN), giving result = all ones, remain = rda and done one cycle after start.
REQ-023 ILLEGAL opcodes SHALL complete like single-cycle ops, with result = 0 and zero = 1.
REQ-024 busy SHALL be high in MUL, DIV and FIN, and low in IDLE.
REQ-025 A start while busy SHALL be ignored, with no effect on state or outputs.
REQ-026 Operands SHALL be latched at acceptance; later changes to rda, rdx or alu_decode SHALL NOT affect an operation in progress.
REQ-027 hi and lo SHALL change only on MUL completion, remain only on DIV completion, and result and zero only at operation completion.
REQ-028 Back-to-back operation: start SHALL be accepted in the cycle after FIN (IDLE), giving one operation per 2 cycles minimum.

Reset
REQ-029 rst SHALL force the following at the next edge, regardless of state (including mid-MUL or mid-DIV):
- state = IDLE;
- busy = 0, done = 0;
- result, hi, lo and remain = 0;
- zero = 1;
- iteration counter and partial registers = 0.
REQ-030 A start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode enum (width M), the FSM state enum and the default N.
REQ-032 MUL/DIV iteration SHALL live in one sub-module, muldiv_iter, with:
- inputs: load, op, operands;
- counter width $clog2(N)+1;
- outputs: 2N-bit product or quotient/remainder, and a finish flag.
REQ-033 seq_alu SHALL own the FSM, the single-cycle datapath and the output registers.

Verification
REQ-034 ADD: start, rda = 5, rdx = 3 -> done next cycle, result = 8, zero = 0.
REQ-035 MUL: rda = 0xFFFFFFFF, rdx = 2 -> done at cycle 33, hi = 0x00000001, lo = 0xFFFFFFFE, busy high cycles 1-33.
REQ-036 DIV: rda = 100, rdx = 7 -> done at cycle 33, result = 14, remain = 2; then DIV with rdx = 0, rda = 9 -> done next cycle, result = 0xFFFFFFFF, remain = 9.
REQ-037 Start during busy: start ADD 1+1 at cycle 5 of a MUL -> ignored, MUL completes correctly, result = MUL lo.
REQ-038 Reset mid-MUL: rst at cycle 10 -> next cycle IDLE, busy = 0, result/hi/lo/remain = 0, zero = 1, no done pulse.
REQ-039 Shift and SLT: SLL 1 by rdx = 0x21 -> result = 2; SLT 3 < 0xFFFFFFFF -> result = 1.
